// File: rtl/rgb_breathe_pwm.sv
// RGB breathing driver: fades one colour in, holds it, fades it out, then
// moves on to the next colour. All level and state changes land on PWM period boundaries.
module rgb_breathe_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int STEP         = 8,
  parameter int HOLD_PERIODS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       redled,
  output logic       greenled,
  output logic       blueled,
  output logic [1:0] color,
  output logic       busy
);

  // state       | meaning
  // S_IDLE      | LEDs off, counters parked at 0, waiting for en
  // S_RAMP_UP   | level rises by STEP each period until it saturates at MAX
  // S_HOLD      | level parked at MAX for HOLD_PERIODS periods
  // S_RAMP_DOWN | level falls by STEP each period, then next colour or idle
  typedef enum logic [1:0] {S_IDLE, S_RAMP_UP, S_HOLD, S_RAMP_DOWN} state_t;

  localparam int                  HOLD_W    = $clog2(HOLD_PERIODS + 1);
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]          color_q, color_d;
  logic [2:0]          led_q, led_d;
  logic                busy_q, busy_d;

  logic                period_end;
  logic                led_on;
  logic [PWM_BITS:0]   level_sum;

  always_comb begin
    state_d    = state_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
    color_d    = color_q;
    period_end = (pwm_cnt_q == MAX);
    level_sum  = {1'b0, level_q} + STEP_W;

    case (state_q)
      S_IDLE: begin
        pwm_cnt_d = '0;
        level_d   = '0;
        if (en) state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (period_end) begin
          if (!en) begin
            state_d = S_RAMP_DOWN;
          end else if (level_sum >= {1'b0, MAX}) begin
            level_d    = MAX;
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            level_d = level_sum[PWM_BITS-1:0];
          end
        end
      end
      S_HOLD: begin
        if (period_end) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
          if (hold_cnt_q == HOLD_LAST || !en) state_d = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (period_end) begin
          if ({1'b0, level_q} <= STEP_W) begin
            level_d = '0;
            if (en) begin
              state_d = S_RAMP_UP;
              color_d = (color_q == 2'd2) ? 2'd0 : color_q + 2'd1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            level_d = level_q - STEP_W[PWM_BITS-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the active colour ever sees the PWM compare; the others stay dark.
    led_on = (state_q != S_IDLE) && (pwm_cnt_q < level_q);
    led_d  = {led_on && (color_q == 2'd0),
              led_on && (color_q == 2'd1),
              led_on && (color_q == 2'd2)};
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      hold_cnt_q <= '0;
      color_q    <= 2'd0;
      led_q      <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      hold_cnt_q <= hold_cnt_d;
      color_q    <= color_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign redled   = led_q[2];
  assign greenled = led_q[1];
  assign blueled  = led_q[0];
  assign color    = color_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Bench for rgb_breathe_pwm: directed breathing scenarios followed by random
// en toggling, all checked cycle by cycle against a period-level reference model.
module tb_rgb_breathe_pwm;

  localparam int PB   = 4;
  localparam int ST   = 4;
  localparam int HP   = 2;
  localparam int MAXV = 15;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_HOLD = 2;
  localparam int M_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       redled, greenled, blueled;
  logic [1:0] color;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int         m_mode, m_phase, m_level, m_held, m_color;
  logic [2:0] exp_led;

  rgb_breathe_pwm #(
    .PWM_BITS    (PB),
    .STEP        (ST),
    .HOLD_PERIODS(HP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .redled  (redled),
    .greenled(greenled),
    .blueled (blueled),
    .color   (color),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_phase = 0;
    m_level = 0;
    m_held  = 0;
    m_color = 0;
    exp_led = 3'b000;
  endtask

  // Advances the reference by one clock edge using the pre-edge values.
  task automatic model_update();
    bool_last_t: begin end
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_led = (m_mode != M_IDLE && m_phase < m_level) ? (3'b100 >> m_color) : 3'b000;
    if (m_mode == M_IDLE) begin
      if (en) begin
        m_mode  = M_UP;
        m_phase = 0;
      end
    end else if (m_phase != MAXV) begin
      m_phase = m_phase + 1;
    end else begin
      m_phase = 0;
      case (m_mode)
        M_UP: begin
          if (!en) m_mode = M_DOWN;
          else if (m_level + ST >= MAXV) begin
            m_level = MAXV;
            m_held  = 0;
            m_mode  = M_HOLD;
          end else m_level = m_level + ST;
        end
        M_HOLD: begin
          if (m_held == HP - 1 || !en) m_mode = M_DOWN;
          m_held = m_held + 1;
        end
        default: begin
          m_level = (m_level <= ST) ? 0 : m_level - ST;
          if (m_level == 0) begin
            if (en) begin
              m_color = (m_color + 1) % 3;
              m_mode  = M_UP;
            end else m_mode = M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("led", {redled, greenled, blueled}, exp_led);
    check("busy", busy, (m_mode != M_IDLE) ? 1 : 0);
    check("color", color, m_color);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  int red_win[11];
  int red_exp[11] = '{0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};
  int dis_win[6];
  int dis_exp[6] = '{0, 4, 8, 8, 4, 0};
  int other_on;

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_led", {redled, greenled, blueled}, 0);
    check("rst_busy", busy, 0);
    check("rst_color", color, 0);
    rst_n = 1'b1;
    repeat (100) step();
    check("idle_busy", busy, 0);

    // Full red breath, then through green and blue back to red.
    en = 1'b1;
    other_on = 0;
    for (int k = 0; k < 11; k++) red_win[k] = 0;
    for (int s = 1; s <= 481; s++) begin
      step();
      if (s >= 2 && s <= 177) red_win[(s - 2) / 16] += int'(redled);
      if (s <= 160) other_on += int'(greenled) + int'(blueled);
      if (s == 1)   check("busy_rise", busy, 1);
      if (s == 17)  check("no_early_pulse", redled, 0);
      if (s == 18)  check("first_pulse", redled, 1);
      if (s == 161) check("color_green", color, 1);
      if (s == 321) check("color_blue", color, 2);
      if (s == 481) check("color_wrap", color, 0);
    end
    for (int k = 0; k < 11; k++) check($sformatf("red_win%0d", k), red_win[k], red_exp[k]);
    check("green_blue_dark", other_on, 0);
    en = 1'b0;
    run_until_idle(200);

    // Early disable at level 8.
    en = 1'b1;
    for (int k = 0; k < 6; k++) dis_win[k] = 0;
    for (int s = 1; s <= 100; s++) begin
      step();
      if (s >= 2 && s <= 97) dis_win[(s - 2) / 16] += int'(redled);
      if (s == 40) en = 1'b0;
      if (s == 80) check("dis_busy_hi", busy, 1);
      if (s == 81) check("dis_busy_lo", busy, 0);
    end
    for (int k = 0; k < 6; k++) check($sformatf("dis_win%0d", k), dis_win[k], dis_exp[k]);
    check("dis_color", color, 0);

    // Drop en in HOLD, re-raise mid ramp-down, then reset during green HOLD.
    en = 1'b1;
    for (int s = 1; s <= 220; s++) begin
      step();
      check("busy_held", busy, 1);
      if (s == 70)  en = 1'b0;
      if (s == 100) en = 1'b1;
      if (s == 145) check("reen_color", color, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", {redled, greenled, blueled}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_color", color, 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (s == 18) check("restart_red", redled, 1);
    end

    // Random en activity.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 39) == 0) en = ~en;
    end
    en = 1'b0;
    run_until_idle(400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
